// File: rtl/id_ex_stage_reg_if.sv
// id_ex_stage_reg_if: decode/execute handshake, operand and writeback bundle for the ID/EX register
interface id_ex_stage_reg_if #(
    parameter int regSize = 128,
    parameter int selBits = 2,
    parameter int opBits  = 4
);
    logic               inValid;
    logic               inReady;
    logic [opBits-1:0]  inOpcode;
    logic [selBits-1:0] inRSel1;
    logic [selBits-1:0] inRSel2;
    logic [selBits-1:0] inRegToWrite;
    logic               inWrEn;
    logic [regSize-1:0] inOperand1;
    logic [regSize-1:0] inOperand2;
    logic               wbWrEn;
    logic [selBits-1:0] wbReg;
    logic [regSize-1:0] wbData;
    logic               flush;
    logic               outValid;
    logic               outReady;
    logic [opBits-1:0]  outOpcode;
    logic [selBits-1:0] outRegToWrite;
    logic               outWrEn;
    logic [regSize-1:0] outOperand1;
    logic [regSize-1:0] outOperand2;

    modport master (
        output inValid, inOpcode, inRSel1, inRSel2, inRegToWrite, inWrEn, inOperand1, inOperand2,
        output wbWrEn, wbReg, wbData, flush, outReady,
        input  inReady, outValid, outOpcode, outRegToWrite, outWrEn, outOperand1, outOperand2
    );

    modport slave (
        input  inValid, inOpcode, inRSel1, inRSel2, inRegToWrite, inWrEn, inOperand1, inOperand2,
        input  wbWrEn, wbReg, wbData, flush, outReady,
        output inReady, outValid, outOpcode, outRegToWrite, outWrEn, outOperand1, outOperand2
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: 2-entry skid-buffered ID/EX register with writeback forwarding into held operands
module id_ex_stage_reg #(
    parameter int regSize = 128,
    parameter int selBits = 2,
    parameter int opBits  = 4
) (
    input logic              clk,
    input logic              reset,
    id_ex_stage_reg_if.slave bus
);
    typedef struct packed {
        logic               valid;
        logic [opBits-1:0]  opcode;
        logic [selBits-1:0] rSel1;
        logic [selBits-1:0] rSel2;
        logic [selBits-1:0] regToWrite;
        logic               wrEn;
        logic [regSize-1:0] operand1;
        logic [regSize-1:0] operand2;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t r_state;
    entry_t r_ent [2];
    entry_t w_fwd [2];
    entry_t w_nxt [2];
    entry_t w_new;
    logic   w_push;
    logic   w_pop;

    assign bus.inReady       = r_state != FULL;
    assign w_push            = bus.inValid && bus.inReady && !bus.flush;
    assign w_pop             = r_ent[0].valid && bus.outReady;
    assign bus.outValid      = r_ent[0].valid;
    assign bus.outOpcode     = r_ent[0].opcode;
    assign bus.outRegToWrite = r_ent[0].regToWrite;
    assign bus.outWrEn       = r_ent[0].wrEn;
    assign bus.outOperand1   = r_ent[0].operand1;
    assign bus.outOperand2   = r_ent[0].operand2;

    // next buffer contents: forward writeback into captured/held operands, then shift/fill/flush
    always_comb begin
        w_new            = '0;
        w_new.valid      = 1'b1;
        w_new.opcode     = bus.inOpcode;
        w_new.rSel1      = bus.inRSel1;
        w_new.rSel2      = bus.inRSel2;
        w_new.regToWrite = bus.inRegToWrite;
        w_new.wrEn       = bus.inWrEn;
        w_new.operand1   = (bus.wbWrEn && bus.wbReg == bus.inRSel1) ? bus.wbData : bus.inOperand1;
        w_new.operand2   = (bus.wbWrEn && bus.wbReg == bus.inRSel2) ? bus.wbData : bus.inOperand2;
        for (int i = 0; i < 2; i++) begin
            w_fwd[i] = r_ent[i];
            if (r_ent[i].valid && bus.wbWrEn && bus.wbReg == r_ent[i].rSel1) w_fwd[i].operand1 = bus.wbData;
            if (r_ent[i].valid && bus.wbWrEn && bus.wbReg == r_ent[i].rSel2) w_fwd[i].operand2 = bus.wbData;
        end
        w_nxt = w_fwd;
        if (bus.flush) begin
            w_nxt[0] = '0;
            w_nxt[1] = '0;
        end else if (w_pop) begin
            w_nxt[0] = r_ent[1].valid ? w_fwd[1] : (w_push ? w_new : '0);
            w_nxt[1] = '0;
        end else if (w_push) begin
            if (!r_ent[0].valid) w_nxt[0] = w_new;
            else w_nxt[1] = w_new;
        end
    end

    // register entries and occupancy state; reset discards everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ent[0] <= '0;
            r_ent[1] <= '0;
            r_state  <= EMPTY;
        end else begin
            r_ent   <= w_nxt;
            r_state <= w_nxt[1].valid ? FULL : (w_nxt[0].valid ? ONE : EMPTY);
        end
    end
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed and random checks of id_ex_stage_reg against a queue-based model
module tb_id_ex_stage_reg;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_chk = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]   op;
        logic [1:0]   s1, s2, rd;
        logic         we;
        logic [127:0] o1, o2;
    } ins_t;

    ins_t q[$];

    id_ex_stage_reg_if #(.regSize(128), .selBits(2), .opBits(4)) bus();

    id_ex_stage_reg #(.regSize(128), .selBits(2), .opBits(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic check_outs();
        check("out_valid", bus.outValid, q.size() > 0);
        check("in_ready", bus.inReady, q.size() < 2);
        if (q.size() > 0) begin
            check("opcode", bus.outOpcode, q[0].op);
            check("reg_to_write", bus.outRegToWrite, q[0].rd);
            check("wr_en", bus.outWrEn, q[0].we);
            check("operand1", bus.outOperand1, q[0].o1);
            check("operand2", bus.outOperand2, q[0].o2);
        end
    endtask

    task automatic set_in(input logic v, input logic [3:0] op, input logic [1:0] s1, input logic [1:0] s2,
                          input logic [1:0] rd, input logic we, input logic [127:0] o1, input logic [127:0] o2);
        bus.inValid = v; bus.inOpcode = op; bus.inRSel1 = s1; bus.inRSel2 = s2;
        bus.inRegToWrite = rd; bus.inWrEn = we; bus.inOperand1 = o1; bus.inOperand2 = o2;
    endtask

    task automatic set_wb(input logic e, input logic [1:0] r, input logic [127:0] d);
        bus.wbWrEn = e; bus.wbReg = r; bus.wbData = d;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // apply one clock of inputs to the model, advance the DUT, compare at the falling edge
    task automatic step();
        bit   push, pop;
        ins_t n;
        push = bus.inValid && q.size() < 2 && !bus.flush;
        pop  = q.size() > 0 && bus.outReady;
        foreach (q[i]) begin
            if (bus.wbWrEn && bus.wbReg == q[i].s1) q[i].o1 = bus.wbData;
            if (bus.wbWrEn && bus.wbReg == q[i].s2) q[i].o2 = bus.wbData;
        end
        n.op = bus.inOpcode; n.s1 = bus.inRSel1; n.s2 = bus.inRSel2;
        n.rd = bus.inRegToWrite; n.we = bus.inWrEn;
        n.o1 = (bus.wbWrEn && bus.wbReg == bus.inRSel1) ? bus.wbData : bus.inOperand1;
        n.o2 = (bus.wbWrEn && bus.wbReg == bus.inRSel2) ? bus.wbData : bus.inOperand2;
        if (pop) void'(q.pop_front());
        if (bus.flush) q.delete();
        if (push) q.push_back(n);
        @(posedge clk);
        @(negedge clk);
        check_outs();
    endtask

    task automatic flush_step();
        bus.flush = 1'b1; bus.inValid = 1'b0;
        step();
        bus.flush = 1'b0;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);
        bus.flush = 1'b0;
        bus.outReady = 1'b0;
        #1 reset = 1'b0;
        #2;
        check("rst_valid", bus.outValid, 0);
        check("rst_opcode", bus.outOpcode, 0);
        check("rst_op1", bus.outOperand1, 0);
        check("rst_op2", bus.outOperand2, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outs();

        // streaming with execute always ready
        bus.outReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(1, 3, 0, 1, 2, 1, 128'h11, 128'h22);
            step();
        end
        bus.inValid = 1'b0;
        step();

        // back-pressure: A, B fill, C ignored, then drain in order
        bus.outReady = 1'b0;
        set_in(1, 4'hA, 0, 1, 1, 1, 128'hA1, 128'hA2); step();
        set_in(1, 4'hB, 2, 3, 2, 0, 128'hB1, 128'hB2); step();
        set_in(1, 4'hC, 0, 0, 3, 1, 128'hC1, 128'hC2); step();
        bus.inValid = 1'b0;
        bus.outReady = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // capture hazard
        bus.outReady = 1'b0;
        set_in(1, 7, 2, 3, 1, 1, 128'h5, 128'h9);
        set_wb(1, 2, 128'hABCD);
        step();
        check("cap_op1", bus.outOperand1, 128'hABCD);
        set_wb(0, 0, 0);
        flush_step();

        // held hazard on stalled head and on skid entry shifting to head
        set_in(1, 5, 0, 1, 0, 1, 128'h101, 128'h102); step();
        set_in(1, 6, 1, 2, 3, 0, 128'h201, 128'h202); step();
        bus.inValid = 1'b0;
        set_wb(1, 1, 128'h77);
        step();
        check("held_op2", bus.outOperand2, 128'h77);
        set_wb(0, 0, 0);
        bus.outReady = 1'b1;
        step();
        check("shift_op1", bus.outOperand1, 128'h77);
        step();

        // flush while full with a simultaneous push
        bus.outReady = 1'b0;
        set_in(1, 1, 0, 0, 0, 0, 128'h1, 128'h1); step();
        set_in(1, 2, 0, 0, 0, 0, 128'h2, 128'h2); step();
        set_in(1, 9, 0, 0, 0, 0, 128'h9, 128'h9);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.inValid = 1'b0;
        bus.outReady = 1'b1;
        step();
        step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 3) != 0, 4'($urandom()), 2'($urandom()), 2'($urandom()),
                   2'($urandom()), 1'($urandom()), rnd128(), rnd128());
            set_wb(1'($urandom()), 2'($urandom()), rnd128());
            bus.outReady = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            bus.flush = $urandom_range(0, 40) == 0;
            step();
        end
        bus.flush = 1'b0;
        set_wb(0, 0, 0);

        // asynchronous reset while full
        bus.outReady = 1'b0;
        set_in(1, 4'hE, 1, 2, 3, 1, 128'hE1, 128'hE2); step();
        set_in(1, 4'hF, 1, 2, 3, 1, 128'hF1, 128'hF2); step();
        check("full_before_rst", bus.inReady, 0);
        bus.inValid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst_valid", bus.outValid, 0);
        check("arst_opcode", bus.outOpcode, 0);
        check("arst_rd", bus.outRegToWrite, 0);
        check("arst_we", bus.outWrEn, 0);
        check("arst_op1", bus.outOperand1, 0);
        check("arst_op2", bus.outOperand2, 0);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        bus.outReady = 1'b1;
        @(negedge clk);
        check_outs();
        step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register that sits directly downstream of the 128-bit scalar register file.
- Captures the two read operands plus instruction control fields and presents them to the execute stage through a valid/ready handshake.
- Contains a 2-entry skid buffer, so back-pressure from execute never drops an instruction.
- Forwards writeback data into captured and held operands, closing the register-file read-during-write hazard.

Parameters:
- regSize, 128, operand width in bits
- selBits, 2, register-select width
- opBits, 4, opcode width

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- inValid  input  1  decode presents a valid instruction this cycle.
- inReady  output  1  stage can accept; a transfer occurs when inValid && inReady.
- inOpcode  input  opBits  decoded opcode.
- inRSel1, inRSel2  input  selBits  source registers; also drive the register-file read selects.
- inRegToWrite  input  selBits  destination register.
- inWrEn  input  1  instruction writes back.
- inOperand1, inOperand2  input  regSize  register-file outputs for inRSel1/inRSel2.
- wbWrEn  input  1  writeback is writing this cycle (same signal as the register-file write enable).
- wbReg  input  selBits  writeback destination.
- wbData  input  regSize  writeback data.
- flush  input  1  synchronous kill of all buffered and incoming instructions.
- outValid  output  1  head entry valid.
- outReady  input  1  execute accepts; a transfer occurs when outValid && outReady.
- outOpcode  output  opBits  head entry opcode.
- outRegToWrite  output  selBits  head entry destination.
- outWrEn  output  1  head entry write enable.
- outOperand1, outOperand2  output  regSize  head entry operands.

Behaviour:
- Storage is 2 entries (head, skid). Each entry holds opcode, rSel1, rSel2, regToWrite, wrEn, operand1, operand2 and valid. Count is 0, 1 or 2.
- States (from count):
  - EMPTY
  - ONE
  - FULL
- inReady is registered and equals (count < 2) from the previous edge, i.e. it is 1 in EMPTY and ONE and 0 in FULL.
  - An upstream transfer in FULL is impossible by construction.
  - inValid in FULL is ignored.
- Outputs are driven directly from the head entry with no combinational path from inputs to outputs. outValid = head.valid.
- Per-edge update, with push = inValid && inReady and pop = outValid && outReady:
  - push only: write into the first free slot (head if EMPTY, skid if ONE); count+1.
  - pop only: skid moves to head, skid is cleared; count-1.
  - push and pop in ONE: new instruction goes to head; count stays 1.
  - push and pop in EMPTY: impossible, because outValid=0.
  - Neither: hold.
- Forwarding at capture: if wbWrEn && wbReg==inRSel1, operand1 captures wbData instead of inOperand1. Operand2 uses the same rule with inRSel2.
- Forwarding while held: every cycle, for each valid entry, if wbWrEn && wbReg==entry.rSel1 then entry.operand1 <= wbData. Operand2 uses the same rule. This also applies to the head while it is stalled by outReady=0.
- Forwarding on pop-shift: the entry moving skid to head also receives the forwarding update that same cycle.
- Forwarding applies regardless of entry.wrEn and even when rSel1==rSel2, in which case both operands update.
- flush:
  - At the edge with flush=1, all entries are invalidated, count=0 and inReady=1 after that edge.
  - Any push in the same cycle is discarded.
  - A pop in the same cycle is still seen by execute, since the handshake completed that cycle.
- Reset (reset=0, asynchronous): all entries are cleared to zero. Outputs go to outValid=0, outOpcode=0, outRegToWrite=0, outWrEn=0, outOperand1/2=0. inReady=1 after reset deasserts.
- Reset mid-operation discards all buffered instructions with no partial state retained.
- Latency: an instruction pushed at edge N is visible on outputs after edge N (1 cycle) when the stage was EMPTY.
- Throughput is 1 instruction per cycle while outReady=1.

Test Plan:
- Reset released, inValid=1 with opcode=3, op1=0x11, op2=0x22, outReady=1 for 4 cycles → outValid=1 one cycle after each push with matching fields; inReady constant 1; no bubbles.
- outReady=0, push A then B → count=2 and inReady=0. Present C → C ignored. Raise outReady → A, then B, then EMPTY, in order with no loss or duplication.
- Capture hazard: inRSel1=2, inOperand1=0x5, wbWrEn=1, wbReg=2, wbData=0xABCD → outOperand1=0xABCD.
- Held hazard: head stalled (outReady=0) with rSel2=1, skid entry rSel1=1, then wbWrEn=1, wbReg=1, wbData=0x77 → head.operand2=0x77. After pop, the new head's operand1=0x77.
- FULL plus flush=1 with simultaneous inValid=1 → next cycle outValid=0, inReady=1, and the discarded instruction never appears.
- Assert reset=0 asynchronously mid-stream with count=2 → outputs 0 and outValid=0 immediately without a clock edge; after release inReady=1 and the buffer is empty.
